// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: icode values, instruction size limits and the
// byte-fetcher FSM state encoding.
package y86_pkg;

   localparam logic [3:0] ICODE_HALT   = 4'h0;
   localparam logic [3:0] ICODE_NOP    = 4'h1;
   localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
   localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
   localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
   localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
   localparam logic [3:0] ICODE_OPQ    = 4'h6;
   localparam logic [3:0] ICODE_JXX    = 4'h7;
   localparam logic [3:0] ICODE_CALL   = 4'h8;
   localparam logic [3:0] ICODE_RET    = 4'h9;
   localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
   localparam logic [3:0] ICODE_POPQ   = 4'hB;

   localparam int unsigned INSTR_BYTES_MAX = 10;
   localparam int unsigned INSTR_W         = 8 * INSTR_BYTES_MAX;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_DONE
   } fetch_state_e;

endpackage

// File: rtl/instr_len_decode.sv
// Instruction length in bytes from icode alone; undefined icodes report one
// byte so the fetch stage can flag them as invalid.
module instr_len_decode
   import y86_pkg::*;
(
   input  logic [3:0] icode,
   output logic [3:0] len_c
);

   always_comb begin
      len_c = 4'd1;
      case (icode)
         ICODE_RRMOVQ, ICODE_OPQ, ICODE_PUSHQ, ICODE_POPQ:
            len_c = 4'd2;
         ICODE_IRMOVQ, ICODE_RMMOVQ, ICODE_MRMOVQ:
            len_c = 4'(INSTR_BYTES_MAX);
         ICODE_JXX, ICODE_CALL:
            len_c = 4'd9;
         default:
            len_c = 4'd1;
      endcase
   end

endmodule

// File: rtl/instr_byte_fetcher.sv
// Gathers one instruction a byte at a time from byte-wide instruction memory
// (single read outstanding) and hands the packed word to fetch.
module instr_byte_fetcher
   import y86_pkg::*;
#(
   parameter int unsigned MEM_SIZE = 1024,
   parameter int unsigned ADDR_W   = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_pc,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   input  logic              mem_rvalid,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [0:INSTR_W-1] instr,
   output logic [ADDR_W-1:0] out_pc,
   output logic              imem_error
);

   localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_SIZE);

   fetch_state_e       state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic [3:0]         len_q, len_d;
   logic [3:0]         dec_len_c;
   logic [ADDR_W-1:0]  pc_d, addr_d;
   logic [0:INSTR_W-1] instr_d;
   logic               err_d;
   logic               rd_en_q, rd_en_d;
   logic               ready_d, valid_d;

   instr_len_decode u_len (
      .icode (mem_rdata[7:4]),
      .len_c (dec_len_c)
   );

   // Strobe is precomputed one cycle early; a flush landing in ISSUE kills it.
   assign mem_rd_en = rd_en_q & ~flush;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      pc_d    = out_pc;
      addr_d  = mem_addr;
      instr_d = instr;
      err_d   = imem_error;

      if (flush) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_valid) begin
                  pc_d    = req_pc;
                  addr_d  = req_pc;
                  cnt_d   = 4'd0;
                  len_d   = 4'd0;
                  instr_d = '0;
                  err_d   = 1'b0;
                  state_d = ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (mem_addr >= MEM_LIMIT) begin
                  err_d   = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (mem_rvalid) begin
                  for (int unsigned k = 0; k < INSTR_BYTES_MAX; k++) begin
                     if (cnt_q == 4'(k)) instr_d[8*k +: 8] = mem_rdata;
                  end
                  cnt_d = cnt_q + 4'd1;
                  // First byte carries the icode that fixes the length.
                  if (cnt_q == 4'd0) len_d = dec_len_c;
                  if (cnt_d == len_d) begin
                     state_d = ST_DONE;
                  end else begin
                     addr_d  = out_pc + ADDR_W'(cnt_d);
                     state_d = ST_ISSUE;
                  end
               end
            end
            ST_DONE: begin
               if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end

      rd_en_d = (state_d == ST_ISSUE) && (addr_d < MEM_LIMIT);
      ready_d = (state_d == ST_IDLE);
      valid_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 4'd0;
         len_q      <= 4'd0;
         out_pc     <= '0;
         mem_addr   <= '0;
         instr      <= '0;
         imem_error <= 1'b0;
         rd_en_q    <= 1'b0;
         req_ready  <= 1'b1;
         out_valid  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         len_q      <= len_d;
         out_pc     <= pc_d;
         mem_addr   <= addr_d;
         instr      <= instr_d;
         imem_error <= err_d;
         rd_en_q    <= rd_en_d;
         req_ready  <= ready_d;
         out_valid  <= valid_d;
      end
   end

endmodule

// File: tb/tb_instr_byte_fetcher.sv
// Randomized bench for instr_byte_fetcher against a length/latency reference
// model and a byte memory with programmable response latency.
module tb_instr_byte_fetcher;

   localparam int unsigned MEM_SIZE = 1024;
   localparam int unsigned ADDR_W   = 64;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              flush;
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_pc;
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_rdata;
   logic              mem_rvalid;
   logic              out_valid;
   logic              out_ready;
   logic [0:79]       instr;
   logic [ADDR_W-1:0] out_pc;
   logic              imem_error;

   logic [7:0]  mem [0:MEM_SIZE-1];
   int          lat;
   int          pend;
   logic [63:0] pend_addr;
   logic [63:0] strobes [$];
   int          checks;
   int          errors;

   instr_byte_fetcher #(.MEM_SIZE(MEM_SIZE), .ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_pc     (req_pc),
      .mem_rd_en  (mem_rd_en),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .mem_rvalid (mem_rvalid),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .instr      (instr),
      .out_pc     (out_pc),
      .imem_error (imem_error)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] rd(input logic [63:0] a);
      if (a < 64'(MEM_SIZE)) return mem[a[9:0]];
      return 8'h00;
   endfunction

   // Memory: answers each strobe after 'lat' cycles (lat=1 -> next cycle).
   always @(posedge clk) begin
      mem_rvalid <= 1'b0;
      if (pend == 1) begin
         mem_rvalid <= 1'b1;
         mem_rdata  <= rd(pend_addr);
      end
      if (pend > 0) pend <= pend - 1;
      if (mem_rd_en) begin
         strobes.push_back(mem_addr);
         if (lat <= 1) begin
            mem_rvalid <= 1'b1;
            mem_rdata  <= rd(mem_addr);
         end else begin
            pend      <= lat - 1;
            pend_addr <= mem_addr;
         end
      end
   end

   function automatic int len_of(input logic [3:0] ic);
      if (ic inside {4'd0, 4'd1, 4'd9})          return 1;
      if (ic inside {4'd2, 4'd6, 4'd10, 4'd11})  return 2;
      if (ic inside {4'd3, 4'd4, 4'd5})          return 10;
      if (ic inside {4'd7, 4'd8})                return 9;
      return 1;
   endfunction

   task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, ".req_ready"},  80'(req_ready),  80'd1);
      chk({tag, ".mem_rd_en"},  80'(mem_rd_en),  80'd0);
      chk({tag, ".mem_addr"},   80'(mem_addr),   80'd0);
      chk({tag, ".out_valid"},  80'(out_valid),  80'd0);
      chk({tag, ".instr"},      instr,           80'd0);
      chk({tag, ".out_pc"},     80'(out_pc),     80'd0);
      chk({tag, ".imem_error"}, 80'(imem_error), 80'd0);
   endtask

   task automatic run_txn(input string tag, input logic [63:0] pc, input int l, input int hold);
      int          len, n_ok, exp_cyc, cyc, room, p;
      logic        err;
      logic [79:0] exp_instr, got_instr;
      bit          seen;

      lat = l;
      exp_instr = '0;
      if (pc >= 64'(MEM_SIZE)) begin
         len  = 0;
         n_ok = 0;
         err  = 1'b1;
      end else begin
         p    = int'(pc[15:0]);
         len  = len_of(mem[p][7:4]);
         room = int'(MEM_SIZE) - p;
         n_ok = (len < room) ? len : room;
         err  = (n_ok < len);
         for (int k = 0; k < n_ok; k++) exp_instr[79-8*k -: 8] = mem[p+k];
      end
      exp_cyc = err ? (2 + n_ok * (l + 1)) : (1 + len * (l + 1));

      strobes.delete();
      @(negedge clk);
      chk({tag, ".req_ready"}, 80'(req_ready), 80'd1);
      req_valid = 1'b1;
      req_pc    = pc;
      @(posedge clk);
      #1 req_valid = 1'b0;

      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 300) begin
         @(negedge clk);
         cyc++;
         if (out_valid) seen = 1'b1;
      end
      chk({tag, ".valid_cycle"}, 80'(cyc), 80'(exp_cyc));
      if (!seen) begin
         rst_n = 1'b0;
         @(negedge clk);
         rst_n = 1'b1;
         return;
      end

      got_instr = instr;
      chk({tag, ".instr"},      got_instr,       exp_instr);
      chk({tag, ".imem_error"}, 80'(imem_error), 80'(err));
      chk({tag, ".out_pc"},     80'(out_pc),     80'(pc));
      chk({tag, ".n_strobe"},   80'(strobes.size()), 80'(n_ok));
      for (int i = 0; i < n_ok && i < strobes.size(); i++)
         chk({tag, ".strobe_addr"}, 80'(strobes[i]), 80'(pc + 64'(i)));

      if (hold > 0) begin
         req_valid = 1'b1;
         req_pc    = {$urandom, $urandom};
         for (int i = 0; i < hold; i++) begin
            chk({tag, ".hold_valid"}, 80'(out_valid), 80'd1);
            chk({tag, ".hold_instr"}, instr,          got_instr);
            chk({tag, ".hold_pc"},    80'(out_pc),    80'(pc));
            chk({tag, ".hold_ready"}, 80'(req_ready), 80'd0);
            @(negedge clk);
         end
         req_valid = 1'b0;
      end

      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      chk({tag, ".idle_ready"}, 80'(req_ready), 80'd1);
      chk({tag, ".idle_valid"}, 80'(out_valid), 80'd0);
   endtask

   task automatic reset_mid_transfer();
      bit got4;
      mem[256] = 8'h30;
      for (int k = 1; k < 10; k++) mem[256+k] = 8'($urandom);
      lat = 2;
      strobes.delete();
      @(negedge clk);
      req_valid = 1'b1;
      req_pc    = 64'd256;
      @(posedge clk);
      #1 req_valid = 1'b0;
      got4 = 1'b0;
      for (int i = 0; i < 100 && !got4; i++) begin
         @(negedge clk);
         if (strobes.size() == 4) got4 = 1'b1;
      end
      chk("rstmid.reached_byte3", 80'(got4), 80'd1);
      rst_n = 1'b0;
      @(negedge clk);
      check_reset_state("rstmid");
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("rstmid.late_instr",  instr,                 80'd0);
      chk("rstmid.late_valid",  80'(out_valid),        80'd0);
      chk("rstmid.late_strobe", 80'(strobes.size()),   80'd4);
      chk("rstmid.late_ready",  80'(req_ready),        80'd1);
   endtask

   task automatic flush_in_issue();
      lat = 1;
      strobes.delete();
      @(negedge clk);
      req_valid = 1'b1;
      req_pc    = 64'h200;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      flush = 1'b1;
      #1;
      chk("flush.rd_en", 80'(mem_rd_en), 80'd0);
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      chk("flush.ready",  80'(req_ready),      80'd1);
      chk("flush.valid",  80'(out_valid),      80'd0);
      chk("flush.strobe", 80'(strobes.size()), 80'd0);
      repeat (3) @(negedge clk);
      chk("flush.still_idle", 80'(out_valid),  80'd0);
      chk("flush.no_strobe",  80'(strobes.size()), 80'd0);
   endtask

   initial begin
      logic [7:0] irm [0:9];
      logic [63:0] pc;
      checks    = 0;
      errors    = 0;
      pend      = 0;
      lat       = 1;
      rst_n     = 1'b0;
      flush     = 1'b0;
      req_valid = 1'b0;
      req_pc    = '0;
      out_ready = 1'b0;
      mem_rdata = 8'h00;
      mem_rvalid = 1'b0;
      for (int i = 0; i < int'(MEM_SIZE); i++) mem[i] = 8'($urandom);

      repeat (2) @(negedge clk);
      check_reset_state("reset");
      rst_n = 1'b1;

      mem[0] = 8'h00;
      run_txn("halt", 64'd0, 1, 0);

      irm = '{8'h30, 8'hF3, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
      for (int k = 0; k < 10; k++) mem[16+k] = irm[k];
      run_txn("irmovq", 64'h10, 1, 0);

      mem[1022] = 8'h30;
      mem[1023] = 8'hF2;
      run_txn("boundary", 64'd1022, 1, 0);

      mem[64] = 8'h80;
      run_txn("call_stall", 64'd64, 3, 5);

      mem[5] = 8'hC0;
      run_txn("invalid", 64'd5, 1, 0);

      run_txn("oob_pc", 64'd2000, 1, 0);
      run_txn("wrap_pc", 64'hFFFF_FFFF_FFFF_FFFF, 2, 0);

      reset_mid_transfer();
      flush_in_issue();

      for (int t = 0; t < 40; t++) begin
         if ($urandom_range(0, 3) == 0) pc = 64'(1014 + $urandom_range(0, 12));
         else                           pc = 64'($urandom_range(0, MEM_SIZE - 1));
         if (pc < 64'(MEM_SIZE)) mem[pc[9:0]] = 8'($urandom);
         run_txn("rand", pc, int'($urandom_range(1, 3)), int'($urandom_range(0, 3)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
